// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the unified memory responder.
// Holds the FSM encoding, the RV32 load/store funct3 codes and the latency counter width.
package mem_resp_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_D = 2'd1,
        S_BUSY_I = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational RV32 byte-lane logic: store merge, load extension and alignment/funct3 checks.
// A store's lane merge is computed unconditionally; the caller decides whether to commit it.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wword,
    output logic [31:0] o_ldata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'h00;
        w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_wword = i_rword;
        o_ldata = 32'h0;
        o_err   = 1'b0;

        case (i_addr_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase

        case (i_funct3)
            F3_B, F3_BU: begin
                o_ldata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
                case (i_addr_lo)
                    2'd0:    o_wword[7:0]   = i_wdata[7:0];
                    2'd1:    o_wword[15:8]  = i_wdata[7:0];
                    2'd2:    o_wword[23:16] = i_wdata[7:0];
                    default: o_wword[31:24] = i_wdata[7:0];
                endcase
            end
            F3_H, F3_HU: begin
                o_err   = i_addr_lo[0];
                o_ldata = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
                if (i_addr_lo[1]) o_wword[31:16] = i_wdata[15:0];
                else              o_wword[15:0]  = i_wdata[15:0];
            end
            F3_W: begin
                o_err   = |i_addr_lo;
                o_ldata = i_rword;
                o_wword = i_wdata;
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-ported memory shared by instruction fetch and load/store, data port wins ties.
// One access in flight; completion is a registered one-cycle ready pulse after WAIT_CYCLES edges.
module unified_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy,
    output state_t      dbg_state
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [2:0]         r_funct3;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept_d;
    logic               w_accept_i;
    logic               w_done;
    logic [31:0]        w_rword;
    logic [31:0]        w_wword;
    logic [31:0]        w_ldata;
    logic               w_err;
    logic               w_unused_addr;

    // Address bits above the decoded range are intentionally dropped so accesses wrap.
    assign w_unused_addr = &{1'b0, if_addr[31:ADDR_W], d_addr[31:ADDR_W]};
    assign w_rword       = r_mem[r_addr[ADDR_W-1:2]];
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

    mem_lane_align u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_rword   (w_rword),
        .i_wdata   (r_wdata),
        .o_wword   (w_wword),
        .o_ldata   (w_ldata),
        .o_err     (w_err)
    );

    always_comb begin
        w_next     = r_state;
        w_accept_d = 1'b0;
        w_accept_i = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    w_accept_d = 1'b1;
                    w_next     = S_BUSY_D;
                end else if (if_req) begin
                    w_accept_i = 1'b1;
                    w_next     = S_BUSY_I;
                end
            end
            S_BUSY_D, S_BUSY_I: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'h0;
        end else if (w_accept_d) begin
            r_cnt    <= CNT_W'(WAIT_CYCLES);
            r_addr   <= d_addr[ADDR_W-1:0];
            r_we     <= d_we;
            r_wdata  <= d_wdata;
            r_funct3 <= d_funct3;
        end else if (w_accept_i) begin
            r_cnt    <= CNT_W'(WAIT_CYCLES);
            r_addr   <= if_addr[ADDR_W-1:0];
            r_we     <= 1'b0;
        end else if (r_state != S_IDLE) begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    // Response registers are pulses: cleared on every edge that is not a completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_ready <= 1'b0;
            if_rdata <= 32'h0;
            d_ready  <= 1'b0;
            d_rdata  <= 32'h0;
            d_err    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            if_rdata <= 32'h0;
            d_ready  <= 1'b0;
            d_rdata  <= 32'h0;
            d_err    <= 1'b0;
            if (w_done && r_state == S_BUSY_I) begin
                if_ready <= 1'b1;
                if_rdata <= w_rword;
            end
            if (w_done && r_state == S_BUSY_D) begin
                d_ready <= 1'b1;
                d_err   <= w_err;
                d_rdata <= (w_err || r_we) ? 32'h0 : w_ldata;
            end
        end
    end

    // The array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_done && r_state == S_BUSY_D && r_we && !w_err) begin
            r_mem[r_addr[ADDR_W-1:2]] <= w_wword;
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboarded bench for unified_mem_responder against a byte-array reference memory.
// Drivers push expected responses at issue time; a negedge monitor pops and compares on ready.
module tb_unified_mem_responder;
    import mem_resp_pkg::*;

    localparam int ADDR_W = 8;
    localparam int W      = 2;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        busy;
    state_t      dbg_state;

    unified_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_funct3  (d_funct3),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0]  m [256];
    logic [33:0] exp_d_q [$];   // {check_rdata, err, rdata}
    logic [31:0] exp_i_q [$];
    logic [33:0] mon_d;
    logic [31:0] mon_i;
    int          n_checks;
    int          n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [33:0] data_ref(input logic we, input logic [31:0] addr,
                                             input logic [31:0] wdata, input logic [2:0] f3);
        logic [7:0]  a;
        logic        err;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] wd;
        logic [31:0] res;
        a = addr[7:0];
        case (f3)
            3'd0, 3'd4: err = 1'b0;
            3'd1, 3'd5: err = a[0];
            3'd2:       err = (a[1:0] != 2'd0);
            default:    err = 1'b1;
        endcase
        if (err) return {1'b1, 1'b1, 32'h0};
        if (we) begin
            case (f3)
                3'd0: m[a] = wdata[7:0];
                3'd1: begin
                    m[a]        = wdata[7:0];
                    m[a | 8'd1] = wdata[15:8];
                end
                default: begin
                    m[a]        = wdata[7:0];
                    m[a | 8'd1] = wdata[15:8];
                    m[a | 8'd2] = wdata[23:16];
                    m[a | 8'd3] = wdata[31:24];
                end
            endcase
            return {1'b0, 1'b0, 32'h0};
        end
        b  = m[a];
        h  = {m[a | 8'd1], m[a]};
        wd = {m[a | 8'd3], m[a | 8'd2], m[a | 8'd1], m[a]};
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd4:    res = {24'h0, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd5:    res = {16'h0, h};
            default: res = wd;
        endcase
        return {1'b1, 1'b0, res};
    endfunction

    function automatic logic [31:0] fetch_ref(input logic [31:0] addr);
        logic [7:0] a;
        a = addr[7:0] & 8'hFC;
        return {m[a | 8'd3], m[a | 8'd2], m[a | 8'd1], m[a]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (d_ready) begin
                if (exp_d_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL d_unexpected: got d_ready=1 expected no data response at %0t", $time);
                end else begin
                    mon_d = exp_d_q.pop_front();
                    chk("d_err", {31'h0, d_err}, {31'h0, mon_d[32]});
                    if (mon_d[33]) chk("d_rdata", d_rdata, mon_d[31:0]);
                end
            end
            if (if_ready) begin
                if (exp_i_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL if_unexpected: got if_ready=1 expected no fetch response at %0t", $time);
                end else begin
                    mon_i = exp_i_q.pop_front();
                    chk("if_rdata", if_rdata, mon_i);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic data_op(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
        int lat;
        lat = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
        exp_d_q.push_back(data_ref(we, addr, wdata, f3));
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'(($urandom)); d_addr = $urandom;
        d_wdata = $urandom; d_funct3 = 3'($urandom);
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (d_ready) begin
                lat = n;
                break;
            end
        end
        chk("d_latency", 32'(lat), 32'(W));
        chk("busy_in_ready_cycle", {31'h0, busy}, 32'h0);
    endtask

    task automatic fetch_op(input logic [31:0] addr);
        int lat;
        lat = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        exp_i_q.push_back(fetch_ref(addr));
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = $urandom;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (if_ready) begin
                lat = n;
                break;
            end
        end
        chk("if_latency", 32'(lat), 32'(W));
    endtask

    // ---------------- main sequence ----------------
    logic [2:0] store_f3 [6];
    int         lat_d;
    int         lat_i;

    initial begin
        store_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        n_checks = 0; n_pass = 0;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_funct3 = 3'h0;
        #1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_d_ready", {31'h0, d_ready}, 32'h0);
        chk("reset_if_ready", {31'h0, if_ready}, 32'h0);
        chk("reset_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) data_op(1'b1, 32'(i * 4), $urandom, F3_W);

        // Directed byte-lane and extension cases.
        data_op(1'b1, 32'h10, 32'hDEADBEEF, F3_W);
        data_op(1'b0, 32'h10, 32'h0, F3_W);
        data_op(1'b1, 32'h11, 32'h00000080, F3_B);
        data_op(1'b0, 32'h10, 32'h0, F3_W);
        data_op(1'b0, 32'h11, 32'h0, F3_B);
        data_op(1'b0, 32'h11, 32'h0, F3_BU);
        data_op(1'b0, 32'h12, 32'h0, F3_H);
        data_op(1'b0, 32'h12, 32'h0, F3_HU);

        // Errors: misaligned store, illegal funct3, misaligned halfword.
        data_op(1'b1, 32'h13, 32'h12345678, F3_W);
        data_op(1'b0, 32'h10, 32'h0, F3_W);
        data_op(1'b0, 32'h10, 32'h0, 3'b011);
        data_op(1'b1, 32'h11, 32'hFFFF, F3_H);
        data_op(1'b0, 32'h10, 32'h0, F3_W);

        // Simultaneous requests: data first, fetch accepted right after the data ready cycle.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_funct3 = F3_W;
        if_req = 1'b1; if_addr = 32'h44;
        exp_d_q.push_back(data_ref(1'b0, 32'h10, 32'h0, F3_W));
        exp_i_q.push_back(fetch_ref(32'h44));
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("tie_state", {30'h0, dbg_state}, {30'h0, S_BUSY_D});
        lat_d = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (d_ready) begin lat_d = n; break; end
        end
        chk("tie_d_latency", 32'(lat_d), 32'(W));
        chk("tie_busy_gap", {31'h0, busy}, 32'h0);
        chk("tie_no_if_ready", {31'h0, if_ready}, 32'h0);
        @(posedge clk); #1;
        chk("tie_fetch_accept", {31'h0, busy}, 32'h1);
        if_req = 1'b0;
        lat_i = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (if_ready) begin lat_i = n; break; end
        end
        chk("tie_if_total_latency", 32'(lat_d + 1 + lat_i), 32'(2 * W + 1));

        // Store aborted by reset one cycle after accept: outputs clear asynchronously.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h0; d_funct3 = F3_W;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_busy", {31'h0, busy}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("async_busy", {31'h0, busy}, 32'h0);
        chk("async_d_ready", {31'h0, d_ready}, 32'h0);
        chk("async_d_err", {31'h0, d_err}, 32'h0);
        chk("async_d_rdata", d_rdata, 32'h0);
        chk("async_if_ready", {31'h0, if_ready}, 32'h0);
        chk("async_if_rdata", if_rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        data_op(1'b0, 32'h10, 32'h0, F3_W);

        // Address wrap above ADDR_W and fetch ignoring low address bits.
        data_op(1'b0, 32'h110, 32'h0, F3_W);
        fetch_op(32'h12);

        // Randomized mix of fetches, loads and stores.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) == 0) begin
                fetch_op(a);
            end else if ($urandom_range(0, 1) == 1) begin
                f3 = store_f3[$urandom_range(0, 5)];
                if ($urandom_range(0, 3) != 0) a = (f3 == F3_H) ? (a & ~32'h1) : (a & ~32'h3);
                data_op(1'b1, a, $urandom, f3);
            end else begin
                f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
                data_op(1'b0, a, 32'h0, f3);
            end
        end

        repeat (W + 3) @(negedge clk);
        chk("d_queue_drained", 32'(exp_d_q.size()), 32'h0);
        chk("if_queue_drained", 32'(exp_i_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
